conv_enc_frame_ctrl: RTL
========================

# conv_enc_frame_ctrl

Frame sequencer for the rate-1/2, constraint-length-3 convolutional encoder. It accepts one frame request at a time and pulls exactly `frame_len` message bits over a valid/ready input handshake. It drives the encoder's 2-bit memory, appends two zero tail bits to flush the trellis, and delivers one registered parity pair per encoded bit over a valid/ready output handshake. It sits between the bit source and the channel mapper.

## Interface
- `LEN_W`, default 8: width of `frame_len`.
- `G0`, default 3'b110: generator for `out_par[0]`. Bit 2 taps the current input, bit 1 taps d1 (previous bit), bit 0 taps d2 (bit before that).
- `G1`, default 3'b111: generator for `out_par[1]`, same tap mapping as `G0`.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: frame request. Sampled only while idle.
- `frame_len` in `LEN_W`: number of message bits. Captured with `start`. 0 is legal.
- `busy` out 1: high while a frame is in progress.
- `in_valid` in 1: message bit available.
- `in_bit` in 1: message bit.
- `in_ready` out 1: controller consumes `in_bit` this cycle.
- `out_valid` out 1: `out_par` is valid.
- `out_par` out 2: {p1, p0}.
- `out_tail` out 1: the current pair was produced by a tail bit.
- `out_ready` in 1: downstream accepts the pair.
- `done` out 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, DATA, TAIL, DRAIN.
  - IDLE: on `start`:
    - capture `frame_len` into the remaining counter;
    - clear d1 and d2 to 0;
    - set the tail counter to 2;
    - go to DATA, or to TAIL if `frame_len` == 0.
  - DATA: on an input accept, decrement the remaining counter. When it reaches 0, go to TAIL.
  - TAIL: feed the encoder the bit 0 with `in_ready` held low. Decrement the tail counter on each slot advance. When it reaches 0, go to DRAIN.
  - DRAIN: when the output register empties (`!out_valid`, or `out_valid && out_ready`), go to IDLE and set `done` for the next cycle.
- Slot advance is allowed when `adv = !out_valid || out_ready`.
- `in_ready = (state == DATA) && adv`. `in_ready` is combinational from state and `out_ready`, never from `in_valid`.
- Input accept is `in_valid && in_ready`.
- On each encode event (an input accept in DATA, or `adv` in TAIL), with u the bit being encoded:
  - `out_par[0] <= ^(G0 & {u, d1, d2})`;
  - `out_par[1] <= ^(G1 & {u, d1, d2})`;
  - `d2 <= d1`, `d1 <= u`;
  - `out_valid <= 1`;
  - `out_tail <= (state == TAIL)`.
- On `adv` with no encode event, `out_valid <= 0`.
- `out_par` and `out_tail` hold their value while `out_valid && !out_ready`.
- A frame emits exactly `frame_len + 2` pairs. The last two pairs have `out_tail` = 1.
- `busy = (state != IDLE)`.
- `start` while busy is ignored, with no effect on the counter or memory.
- `start` in the same cycle as `done` = 1 is accepted, because the state is IDLE.
- Input bits offered outside DATA are not consumed.

## Timing
- Reset values (asynchronous): state = IDLE, d1 = d2 = 0, counters = 0, `out_valid` = 0, `out_par` = 2'b00, `out_tail` = 0, `done` = 0. This gives `busy` = 0 and `in_ready` = 0.
- `RST` asserted mid-frame aborts the frame immediately. The partial output is discarded and no `done` is issued.
- Latency: a bit accepted at edge k is presented as a pair from edge k+1.
- Throughput: 1 pair per cycle with `out_ready` held high.
- Cycle budget, with `out_ready` = 1 and `in_valid` = 1 throughout:
  - `start` at edge 0;
  - data accepts at edges 1 .. N;
  - tail slots at edges N+1 and N+2;
  - DRAIN at edge N+3;
  - `done` high for the cycle after edge N+3.
- Backpressure: with `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0 and the encoder memory is frozen.
- `done` is high for exactly one cycle per completed frame.

## Test plan
- Basic frame, defaults, `frame_len` = 4, bits 1,0,1,1, `out_ready` = 1. Required `out_par` sequence: 11, 11, 01, 00, 01, 10. `out_tail` = 0,0,0,0,1,1. `done` pulses once, and `busy` falls in the same cycle that `done` rises.
- `frame_len` = 0: exactly two pairs, both 00 with `out_tail` = 1. `in_ready` never asserts.
- Backpressure: same stimulus as the basic frame, with `out_ready` toggling 1,0,0,1,... and `in_valid` gapped randomly. The pair sequence must be identical to the basic frame. `out_par` must be stable while stalled, and no bit may be lost or duplicated.
- `start` pulsed during DATA with a different `frame_len`: it is ignored and the original frame completes. Back-to-back frames, with `start` in the `done` cycle, are accepted; the second frame begins with d1 = d2 = 0.
- Reset mid-frame, after 2 of 4 bits: all outputs return to their reset values asynchronously and no `done` is issued. The next frame, bits 1,0,1,1, again yields 11, 11, 01, 00, 01, 10.
- `frame_len` = 2^`LEN_W` − 1 = 255 with random bits, checked against a reference model. The bench confirms exactly 257 pairs are emitted and the counter does not wrap.

Source files
------------

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for a rate-1/2, K=3 convolutional encoder.
// Pulls frame_len message bits over a valid/ready input, appends two zero
// tail bits to flush the trellis, and emits one registered parity pair per
// encoded bit over a valid/ready output.
module conv_enc_frame_ctrl #(
    parameter int         LEN_W = 8,
    parameter logic [2:0] G0    = 3'b110,
    parameter logic [2:0] G1    = 3'b111
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_par,
    output logic             out_tail,
    input  logic             out_ready,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Generators packed so parity bit gi uses slice [gi*3 +: 3].
    localparam logic [5:0] GENS = {G1, G0};

    logic [1:0]       state_reg;
    logic [LEN_W-1:0] rem_reg;
    logic [1:0]       tail_reg;
    logic             d1_reg;
    logic             d2_reg;
    logic             out_valid_reg;
    logic [1:0]       out_par_reg;
    logic             out_tail_reg;
    logic             done_reg;

    logic       adv;
    logic       accept;
    logic       encode;
    logic       start_accept;
    logic       u_bit;
    logic [2:0] taps;
    logic [1:0] par_next;

    // A slot may advance whenever the output register is empty or draining.
    assign adv          = !out_valid_reg || out_ready;
    assign in_ready     = (state_reg == ST_DATA) && adv;
    assign accept       = in_valid && in_ready;
    assign encode       = accept || ((state_reg == ST_TAIL) && adv);
    assign start_accept = (state_reg == ST_IDLE) && start;
    // Tail slots feed zeros into the encoder.
    assign u_bit        = (state_reg == ST_DATA) ? in_bit : 1'b0;
    assign taps         = {u_bit, d1_reg, d2_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_par
            assign par_next[gi] = ^(GENS[gi*3 +: 3] & taps);
        end
    endgenerate

    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = out_valid_reg;
    assign out_par   = out_par_reg;
    assign out_tail  = out_tail_reg;
    assign done      = done_reg;

    // Frame sequencing: state, message/tail counters and completion pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
            tail_reg  <= 2'd0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        rem_reg   <= frame_len;
                        tail_reg  <= 2'd2;
                        state_reg <= (frame_len == '0) ? ST_TAIL : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        rem_reg <= rem_reg - LEN_W'(1);
                        if (rem_reg == LEN_W'(1)) begin
                            state_reg <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (adv) begin
                        tail_reg <= tail_reg - 2'd1;
                        if (tail_reg == 2'd1) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    // Leave only once the last pair has been taken.
                    if (adv) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Encoder memory and registered parity output with hold under backpressure.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d1_reg        <= 1'b0;
            d2_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            out_par_reg   <= 2'b00;
            out_tail_reg  <= 1'b0;
        end else begin
            if (start_accept) begin
                d1_reg <= 1'b0;
                d2_reg <= 1'b0;
            end else if (encode) begin
                d2_reg <= d1_reg;
                d1_reg <= u_bit;
            end
            if (encode) begin
                out_par_reg   <= par_next;
                out_valid_reg <= 1'b1;
                out_tail_reg  <= (state_reg == ST_TAIL);
            end else if (adv) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule
